// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command path: opcodes, parser states, operand register addresses.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU     = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  // Register-file slots that hold the ALU operands
  localparam int unsigned REG_OPA = 0;
  localparam int unsigned REG_OPB = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_ISSUE,
    ST_ALU_OPA,
    ST_ALU_OPB,
    ST_ALU_FUN,
    ST_ALU_ISSUE
  } parser_state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD) || (b == OP_ALU) || (b == OP_ALU_NOP);
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Saturating inter-byte timeout counter with clear, run and expire.
// Latency: expire reflects the registered count; clear/run take effect on the next edge.
// Backpressure: none; run simply pauses counting when low.
module cmd_timeout_cnt #(
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  // Terminal count; with the timeout disabled the counter just parks at all-ones
  localparam logic [TMO_W-1:0] LIMIT = (TIMEOUT == 0) ? {TMO_W{1'b1}} : TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // Clear wins over counting; stop at the terminal count instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// Assembles UART bytes into write/read/ALU command frames and issues one-cycle strobes.
// Latency: every output is registered, one cycle after the causing byte or CMD_BUSY-low cycle.
// Backpressure: read/ALU issue waits while CMD_BUSY is high; no backpressure towards the receiver.
module uart_rx_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TMO_W   = 16,
  parameter int TIMEOUT = 20000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              RX_PAR_ERR,
  input  logic              RX_STP_ERR,
  input  logic              CMD_BUSY,
  output logic              WR_EN,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] ADDR,
  output logic [7:0]        WR_DATA,
  output logic              ALU_EN,
  output logic [3:0]        ALU_FUN,
  output logic              CMD_ERR
);

  parser_state_e     state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              alu_en_q, alu_en_d;
  logic              cmd_err_q, cmd_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [3:0]        alu_fun_q, alu_fun_d;

  logic byte_err, byte_acc, tmo_run, tmo_expire, tmo_abort, tmo_clr;

  assign byte_err  = RX_D_VLD && (RX_PAR_ERR || RX_STP_ERR);
  assign byte_acc  = RX_D_VLD && !RX_PAR_ERR && !RX_STP_ERR;
  // Only the byte-collecting states are subject to the inter-byte timeout
  assign tmo_run   = state_q inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                     ST_ALU_OPA, ST_ALU_OPB, ST_ALU_FUN};
  // A byte arriving on the expiry cycle takes precedence over the timeout
  assign tmo_abort = tmo_run && tmo_expire && !RX_D_VLD;
  assign tmo_clr   = (state_d != state_q) || byte_acc;

  cmd_timeout_cnt #(
    .TMO_W   (TMO_W),
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (CLK),
    .rst    (RST),
    .clr    (tmo_clr),
    .run    (tmo_run),
    .expire (tmo_expire)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: bad bytes and timeouts abort from anywhere, otherwise walk the frame
  always_comb begin
    state_d = state_q;
    if (byte_err || tmo_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_acc) begin
            case (RX_P_DATA)
              OP_WR:      state_d = ST_WR_ADDR;
              OP_RD:      state_d = ST_RD_ADDR;
              OP_ALU:     state_d = ST_ALU_OPA;
              OP_ALU_NOP: state_d = ST_ALU_FUN;
              default:    state_d = ST_IDLE;
            endcase
          end
        end
        ST_WR_ADDR:   if (byte_acc) state_d = ST_WR_DATA;
        ST_WR_DATA:   if (byte_acc) state_d = ST_IDLE;
        ST_RD_ADDR:   if (byte_acc) state_d = ST_RD_ISSUE;
        ST_ALU_OPA:   if (byte_acc) state_d = ST_ALU_OPB;
        ST_ALU_OPB:   if (byte_acc) state_d = ST_ALU_FUN;
        ST_ALU_FUN:   if (byte_acc) state_d = ST_ALU_ISSUE;
        ST_RD_ISSUE,
        ST_ALU_ISSUE: if (RX_D_VLD || !CMD_BUSY) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode: strobes default low, data outputs hold between strobes
  always_comb begin
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;
    addr_d     = addr_q;
    addr_lat_d = addr_lat_q;
    wr_data_d  = wr_data_q;
    alu_fun_d  = alu_fun_q;
    if (byte_err || tmo_abort) begin
      cmd_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_acc && !is_opcode(RX_P_DATA)) cmd_err_d = 1'b1;
        end
        ST_WR_ADDR, ST_RD_ADDR: begin
          if (byte_acc) addr_lat_d = RX_P_DATA[ADDR_W-1:0];
        end
        ST_WR_DATA: begin
          if (byte_acc) begin
            wr_en_d   = 1'b1;
            addr_d    = addr_lat_q;
            wr_data_d = RX_P_DATA;
          end
        end
        ST_ALU_OPA, ST_ALU_OPB: begin
          if (byte_acc) begin
            wr_en_d   = 1'b1;
            addr_d    = (state_q == ST_ALU_OPA) ? ADDR_W'(REG_OPA) : ADDR_W'(REG_OPB);
            wr_data_d = RX_P_DATA;
          end
        end
        ST_ALU_FUN: begin
          if (byte_acc) alu_fun_d = RX_P_DATA[3:0];
        end
        ST_RD_ISSUE: begin
          if (RX_D_VLD) begin
            cmd_err_d = 1'b1;
          end else if (!CMD_BUSY) begin
            rd_en_d = 1'b1;
            addr_d  = addr_lat_q;
          end
        end
        ST_ALU_ISSUE: begin
          if (RX_D_VLD) begin
            cmd_err_d = 1'b1;
          end else if (!CMD_BUSY) begin
            alu_en_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and address-latch registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      addr_q     <= '0;
      addr_lat_q <= '0;
      wr_data_q  <= '0;
      alu_fun_q  <= '0;
    end else begin
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      cmd_err_q  <= cmd_err_d;
      addr_q     <= addr_d;
      addr_lat_q <= addr_lat_d;
      wr_data_q  <= wr_data_d;
      alu_fun_q  <= alu_fun_d;
    end
  end

  assign WR_EN   = wr_en_q;
  assign RD_EN   = rd_en_q;
  assign ALU_EN  = alu_en_q;
  assign CMD_ERR = cmd_err_q;
  assign ADDR    = addr_q;
  assign WR_DATA = wr_data_q;
  assign ALU_FUN = alu_fun_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Bench for uart_rx_cmd_parser: directed frames with literal expectations, then random byte streams.
// Latency: a frame-level model predicts each registered output one cycle after its cause.
// Backpressure: CMD_BUSY is driven directly and randomly by the bench.
module tb_uart_rx_cmd_parser;

  localparam int AW     = 4;
  localparam int TB_TMO = 200;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_vld, rx_perr, rx_serr, busy;
  logic          wr_en, rd_en, alu_en, cmd_err;
  logic [AW-1:0] addr;
  logic [7:0]    wr_data;
  logic [3:0]    alu_fun;

  int checks = 0;
  int errors = 0;

  uart_rx_cmd_parser #(
    .ADDR_W  (AW),
    .TMO_W   (16),
    .TIMEOUT (TB_TMO)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .RX_P_DATA  (rx_data),
    .RX_D_VLD   (rx_vld),
    .RX_PAR_ERR (rx_perr),
    .RX_STP_ERR (rx_serr),
    .CMD_BUSY   (busy),
    .WR_EN      (wr_en),
    .RD_EN      (rd_en),
    .ADDR       (addr),
    .WR_DATA    (wr_data),
    .ALU_EN     (alu_en),
    .ALU_FUN    (alu_fun),
    .CMD_ERR    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit            e_wr, e_rd, e_alu, e_err;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_wdata;
  logic [3:0]    e_fun;
  logic [7:0]    frm[$];
  int            pend;      // 0 none, 1 read pending, 2 ALU pending
  logic [AW-1:0] pend_addr;
  int            idle;

  function automatic bit known_op(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
  endfunction

  always @(posedge clk) begin
    logic [7:0] a_byte;
    int n;
    e_wr = 0; e_rd = 0; e_alu = 0; e_err = 0;
    if (rst) begin
      e_addr = '0; e_wdata = '0; e_fun = '0;
      frm.delete(); pend = 0; idle = 0; pend_addr = '0;
    end else if (rx_vld && (rx_perr || rx_serr)) begin
      e_err = 1; frm.delete(); pend = 0; idle = 0;
    end else if (rx_vld) begin
      idle = 0;
      if (pend != 0) begin
        e_err = 1; pend = 0;
      end else if (frm.size() == 0) begin
        if (known_op(rx_data)) frm.push_back(rx_data);
        else e_err = 1;
      end else begin
        frm.push_back(rx_data);
        n = frm.size();
        case (frm[0])
          8'hAA: if (n == 3) begin
            a_byte = frm[1];
            e_wr = 1; e_addr = a_byte[AW-1:0]; e_wdata = rx_data;
            frm.delete();
          end
          8'hBB: begin
            a_byte = frm[1];
            pend = 1; pend_addr = a_byte[AW-1:0];
            frm.delete();
          end
          8'hCC: begin
            if (n == 2) begin e_wr = 1; e_addr = 0; e_wdata = rx_data; end
            else if (n == 3) begin e_wr = 1; e_addr = 1; e_wdata = rx_data; end
            else begin e_fun = rx_data[3:0]; pend = 2; frm.delete(); end
          end
          default: begin
            e_fun = rx_data[3:0]; pend = 2; frm.delete();
          end
        endcase
      end
    end else begin
      if (pend != 0) begin
        if (!busy) begin
          if (pend == 1) begin e_rd = 1; e_addr = pend_addr; end
          else e_alu = 1;
          pend = 0;
        end
      end else if (frm.size() != 0) begin
        idle++;
        if (idle == TB_TMO) begin
          e_err = 1; frm.delete(); idle = 0;
        end
      end
    end
    #1;
    chk("wr_en", wr_en, e_wr);
    chk("rd_en", rd_en, e_rd);
    chk("alu_en", alu_en, e_alu);
    chk("cmd_err", cmd_err, e_err);
    chk("addr", addr, e_addr);
    chk("wr_data", wr_data, e_wdata);
    chk("alu_fun", alu_fun, e_fun);
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input bit pe = 0, input bit se = 0);
    rx_data = b; rx_vld = 1; rx_perr = pe; rx_serr = se;
    @(negedge clk);
    rx_vld = 0; rx_perr = 0; rx_serr = 0;
  endtask

  task automatic gap(input int n, input bit rnd_busy = 0);
    repeat (n) begin
      @(negedge clk);
      if (rnd_busy) busy = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    logic [7:0] ops [4];
    int r;
    ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
    rst = 1; rx_data = 0; rx_vld = 0; rx_perr = 0; rx_serr = 0; busy = 0;
    gap(3);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_addr", addr, 0);
    rst = 0;
    gap(2);

    // write with wide byte spacing
    send_byte(8'hAA); gap(159);
    send_byte(8'h05); gap(159);
    send_byte(8'h3C);
    chk("t1_wr_en", wr_en, 1);
    chk("t1_addr", addr, 5);
    chk("t1_wr_data", wr_data, 8'h3C);
    gap(3);

    // ALU with operands, back-to-back bytes
    send_byte(8'hCC);
    send_byte(8'h12);
    chk("t2_opa_wr", wr_en, 1);
    chk("t2_opa_addr", addr, 0);
    chk("t2_opa_data", wr_data, 8'h12);
    send_byte(8'h34);
    chk("t2_opb_addr", addr, 1);
    chk("t2_opb_data", wr_data, 8'h34);
    send_byte(8'h07);
    gap(1);
    chk("t2_alu_en", alu_en, 1);
    chk("t2_alu_fun", alu_fun, 7);
    gap(3);

    // read held off by CMD_BUSY
    busy = 1;
    send_byte(8'hBB);
    send_byte(8'h03);
    gap(10);
    chk("t3_rd_busy", rd_en, 0);
    busy = 0;
    gap(1);
    chk("t3_rd_en", rd_en, 1);
    chk("t3_addr", addr, 3);
    gap(3);

    // parity error aborts, following write is clean
    send_byte(8'hAA);
    send_byte(8'h02, 1, 0);
    chk("t4_cmd_err", cmd_err, 1);
    chk("t4_no_wr", wr_en, 0);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h55);
    chk("t4_wr_en", wr_en, 1);
    chk("t4_addr", addr, 2);
    chk("t4_wr_data", wr_data, 8'h55);
    gap(3);

    // unknown opcode, then timeout, then read
    send_byte(8'h7E);
    chk("t5_bad_op", cmd_err, 1);
    gap(2);
    send_byte(8'hAA);
    gap(TB_TMO - 1);
    chk("t5_tmo_early", cmd_err, 0);
    gap(1);
    chk("t5_tmo", cmd_err, 1);
    gap(2);
    send_byte(8'hBB);
    send_byte(8'h01);
    gap(1);
    chk("t5_rd_en", rd_en, 1);
    chk("t5_addr", addr, 1);
    gap(3);

    // reset mid-frame
    send_byte(8'hCC);
    send_byte(8'h11);
    rst = 1;
    gap(1);
    chk("t6_rst_err", cmd_err, 0);
    chk("t6_rst_data", wr_data, 0);
    chk("t6_rst_wr", wr_en, 0);
    rst = 0;
    gap(1);
    send_byte(8'hDD);
    send_byte(8'h0A);
    gap(1);
    chk("t6_alu_en", alu_en, 1);
    chk("t6_alu_fun", alu_fun, 4'hA);
    gap(3);

    // random byte streams
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      bit pe, se;
      b  = ($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, 3)] : 8'($urandom);
      pe = ($urandom_range(0, 29) == 0);
      se = ($urandom_range(0, 29) == 0);
      send_byte(b, pe, se);
      r = $urandom_range(0, 39);
      if (r < 20)      gap(0, 1);
      else if (r < 34) gap($urandom_range(1, 3), 1);
      else if (r < 35) gap($urandom_range(TB_TMO - 2, TB_TMO + 1), 0);
      else             gap($urandom_range(4, 20), 1);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        gap(1);
        rst = 0;
      end
    end
    busy = 0;
    gap(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_parser.md
# uart_rx_cmd_parser

Byte-level command parser directly downstream of the UART receiver. It consumes the receiver's parallel byte stream and its per-byte error flags, and assembles multi-byte command frames. From each complete frame it issues single-cycle register-file write/read and ALU-operation strobes to the system control path. Erroneous bytes, unknown opcodes and stalled frames abort the frame and are flagged.

## Interface
- ADDR_W, 4: register-file address width; address bytes are truncated to their low ADDR_W bits.
- TMO_W, 16: width of the inter-byte timeout counter.
- TIMEOUT, 20000: maximum CLK cycles between bytes of one frame; 0 disables the timeout.
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- RX_P_DATA  in  8  received byte, valid while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle byte-valid strobe from the UART receiver.
- RX_PAR_ERR  in  1  parity error for the current byte; sampled only when RX_D_VLD=1.
- RX_STP_ERR  in  1  framing (stop-bit) error for the current byte; sampled only when RX_D_VLD=1.
- CMD_BUSY  in  1  downstream result path busy; read and ALU issue stalls while it is high.
- WR_EN  out  1  register-file write strobe (one cycle).
- RD_EN  out  1  register-file read strobe (one cycle).
- ADDR  out  ADDR_W  register-file address, valid with WR_EN or RD_EN.
- WR_DATA  out  8  register-file write data, valid with WR_EN.
- ALU_EN  out  1  ALU operation strobe (one cycle).
- ALU_FUN  out  4  ALU function code, valid with ALU_EN.
- CMD_ERR  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Frame formats (opcode byte first):
  - 0xAA: write. Bytes are opcode, addr, data.
  - 0xBB: read. Bytes are opcode, addr.
  - 0xCC: ALU with operands. Bytes are opcode, opA, opB, fun.
  - 0xDD: ALU without operands. Bytes are opcode, fun.
- States:
  - IDLE → WR_ADDR on 0xAA, RD_ADDR on 0xBB, ALU_OPA on 0xCC, ALU_FUN on 0xDD.
  - WR_ADDR → WR_DATA.
  - WR_DATA → IDLE.
  - RD_ADDR → RD_ISSUE.
  - ALU_OPA → ALU_OPB → ALU_FUN.
  - ALU_FUN → ALU_ISSUE.
  - RD_ISSUE and ALU_ISSUE → IDLE.
- A byte is "accepted" when RX_D_VLD=1, RX_PAR_ERR=0 and RX_STP_ERR=0.
- WR_DATA byte accepted: pulse WR_EN with the latched ADDR and WR_DATA=byte.
- ALU_OPA byte accepted: pulse WR_EN with ADDR=0 and WR_DATA=byte.
- ALU_OPB byte accepted: pulse WR_EN with ADDR=1 and WR_DATA=byte.
- ALU_FUN byte: latch the low nibble into ALU_FUN; the upper nibble is ignored.
- RD_ISSUE: hold while CMD_BUSY=1. Pulse RD_EN in the first cycle CMD_BUSY=0, then go to IDLE.
- ALU_ISSUE: hold while CMD_BUSY=1. Pulse ALU_EN in the first cycle CMD_BUSY=0, then go to IDLE.
- Abort conditions. Each pulses CMD_ERR for one cycle and sends the FSM to IDLE.
  - RX_D_VLD=1 with either error flag set, in any state. The byte is discarded.
  - Unknown opcode in IDLE.
  - Any byte arriving in RD_ISSUE or ALU_ISSUE. The pending issue is cancelled.
  - Timeout expiry.
- Timeout counter:
  - Counts only in WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB and ALU_FUN.
  - Clears on every state change and on every accepted byte.
  - Expires when the count reaches TIMEOUT-1; it saturates and never wraps.
  - Disabled when TIMEOUT=0.
- Simultaneous timeout expiry and byte arrival: the byte wins; the counter clears.

## Timing
- Every output is registered and appears exactly one CLK cycle after the RX_D_VLD cycle (or the CMD_BUSY-low cycle) that causes it.
- Strobes are one cycle wide. At most one of WR_EN, RD_EN, ALU_EN, CMD_ERR is high in any cycle.
- ADDR, WR_DATA and ALU_FUN hold their last values between strobes.
- Reset: all outputs are 0, the FSM is in IDLE and the timeout counter is 0.
- Reset asserted mid-frame discards the partial frame with no CMD_ERR pulse.
- Back-to-back RX_D_VLD on consecutive cycles must be handled. There is no minimum byte spacing.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the opcode constants (0xAA, 0xBB, 0xCC, 0xDD);
  - the parser state enum;
  - the operand register addresses (0 and 1).
- One sub-module, `cmd_timeout_cnt`: a saturating TMO_W-bit counter with clear, run and expire. It is reusable for the TX-side control path.

## Test plan
- Bytes AA, 05, 3C, with RX_D_VLD pulses 160 cycles apart → one WR_EN, ADDR=5, WR_DATA=0x3C, one cycle after the third strobe.
- Bytes CC, 12, 34, 07 → WR_EN (ADDR=0, WR_DATA=0x12), then WR_EN (ADDR=1, WR_DATA=0x34), then ALU_EN with ALU_FUN=7.
- Bytes BB, 03 with CMD_BUSY high for 10 cycles → no RD_EN while busy; RD_EN with ADDR=3 in the cycle after CMD_BUSY falls.
- Bytes AA, 02 (with RX_PAR_ERR=1), then AA, 02, 55 → CMD_ERR on the bad byte, no write; the following write completes normally.
- Byte 0x7E in IDLE → CMD_ERR. Byte AA then silence for TIMEOUT cycles → CMD_ERR and IDLE; a subsequent BB, 01 → RD_EN.
- RST pulsed after bytes CC, 11 → all outputs 0, no CMD_ERR; then bytes DD, 0A → ALU_EN with ALU_FUN=0xA.
